// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, state type and size helper for the data-memory arbiter
`ifndef DATA_MEM_SIZE
`define DATA_MEM_SIZE 1024
`endif

package dmem_pkg;
    localparam logic [2:0] SZ_B = 3'd1;
    localparam logic [2:0] SZ_H = 3'd2;
    localparam logic [2:0] SZ_W = 3'd4;

    localparam int REQ_CORE = 0;
    localparam int REQ_DBG  = 1;

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } dmem_state_t;

    function automatic logic size_legal(input logic [2:0] sz);
        return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W);
    endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, response and memory-side signals of the data-memory arbiter
interface dmem_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_store;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [5:0]  req_size;
    logic [1:0]  req_sign;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_store;
    logic        mem_load;
    logic [2:0]  mem_size;
    logic        mem_sign;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_addr, req_wdata, req_size, req_sign, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output mem_addr, mem_wdata, mem_store, mem_load, mem_size, mem_sign
    );

    modport master (
        output req_valid, req_store, req_addr, req_wdata, req_size, req_sign, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  mem_addr, mem_wdata, mem_store, mem_load, mem_size, mem_sign
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way round-robin grant with its own preference pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic ptr_q;

    always_comb begin
        gnt = 2'b00;
        if (req[ptr_q]) begin
            gnt[ptr_q] = 1'b1;
        end else if (req[~ptr_q]) begin
            gnt[~ptr_q] = 1'b1;
        end
    end

    // Preference moves to whichever requester lost the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr_q <= gnt[0];
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - arbitrates core and debug ports onto the data memory and returns tagged responses
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = `DATA_MEM_SIZE,
    parameter int NREQ      = 2
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    if (NREQ != 2) begin : g_nreq_check
        $error("dmem_arbiter supports exactly two requesters");
    end

    dmem_state_t state_q, state_d;
    logic [1:0]  arb_req, gnt;
    logic        granted, win;
    logic [31:0] sel_addr, sel_wdata;
    logic [2:0]  sel_size;
    logic        sel_store, sel_sign;
    logic        range_err, acc_err, do_store, do_load;
    logic        pend_q;
    logic [1:0]  rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    assign arb_req = (state_q == IDLE) ? bus.req_valid : 2'b00;

    rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (granted),
        .gnt     (gnt)
    );

    assign granted   = |gnt;
    assign win       = gnt[REQ_DBG];
    assign sel_addr  = win ? bus.req_addr[63:32]  : bus.req_addr[31:0];
    assign sel_wdata = win ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
    assign sel_size  = win ? bus.req_size[5:3]    : bus.req_size[2:0];
    assign sel_store = win ? bus.req_store[1]     : bus.req_store[0];
    assign sel_sign  = win ? bus.req_sign[1]      : bus.req_sign[0];

    // 33-bit sum so an address near the top of the 32-bit space cannot wrap into range.
    assign range_err = ({1'b0, sel_addr} + {30'd0, sel_size}) > 33'(MEM_BYTES);
    assign acc_err   = !size_legal(sel_size) || range_err;
    assign do_store  = granted && sel_store && !acc_err;
    assign do_load   = granted && !sel_store && !acc_err;

    assign bus.req_ready = gnt;
    assign bus.mem_store = do_store;
    assign bus.mem_load  = do_load;
    assign bus.mem_addr  = granted ? sel_addr  : 32'd0;
    assign bus.mem_wdata = granted ? sel_wdata : 32'd0;
    assign bus.mem_size  = granted ? sel_size  : 3'd0;
    assign bus.mem_sign  = granted ? sel_sign  : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (do_load) state_d = LOAD_WAIT;
            LOAD_WAIT: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Stores and errors answer one cycle after the grant; loads answer after the read-latency cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            pend_q      <= 1'b0;
        end else if (state_q == LOAD_WAIT) begin
            rsp_valid_q <= pend_q ? 2'b10 : 2'b01;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= bus.mem_rdata;
        end else begin
            rsp_valid_q <= (granted && !do_load) ? gnt : 2'b00;
            rsp_err_q   <= granted && acc_err;
            rsp_rdata_q <= 32'd0;
            if (do_load) begin
                pend_q <= win;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized scoreboard bench for dmem_arbiter with a byte-array memory model
`ifndef DATA_MEM_SIZE
`define DATA_MEM_SIZE 1024
`endif

module tb_dmem_arbiter;
    localparam int MEM_BYTES = `DATA_MEM_SIZE;

    typedef struct {
        bit          st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  size;
        bit          sign;
        int          gap;
    } req_t;

    typedef struct {
        int          due;
        bit          err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct packed {
        bit          skip;
        logic [1:0]  ready;
        logic        st;
        logic        ld;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic        sign;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   done = 1'b0;
    bit   drain_timeout = 1'b0;

    rsp_t rsp_q [2][$];
    cyc_t cyc_q [$];

    dmem_arbiter_if ifc ();

    dmem_arbiter #(
        .MEM_BYTES (MEM_BYTES),
        .NREQ      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model and reference helpers ----------------
    logic [7:0]  mem_arr [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic        mem_ld_q = 1'b0;
    logic [31:0] mem_rd_q = 32'd0;

    function automatic int bidx(input logic [31:0] a, input int k);
        return int'((a + 32'(k)) % 32'(MEM_BYTES));
    endfunction

    function automatic logic [31:0] peek(input bit from_ref, input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] raw;
        raw = 32'd0;
        for (int k = 0; k < 4; k++)
            if (k < int'(sz)) raw[8*k +: 8] = from_ref ? ref_mem[bidx(a, k)] : mem_arr[bidx(a, k)];
        return raw;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] sz, input logic sg);
        case (sz)
            3'd1:    return sg ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
            3'd2:    return sg ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign ifc.mem_rdata = mem_ld_q ? mem_rd_q : ifc.mem_addr;

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem_arr[i] = 8'd0;
        forever begin
            @(posedge clk);
            if (ifc.mem_store)
                for (int k = 0; k < int'(ifc.mem_size); k++)
                    mem_arr[bidx(ifc.mem_addr, k)] <= ifc.mem_wdata[8*k +: 8];
            mem_ld_q <= ifc.mem_load;
            mem_rd_q <= extend(peek(1'b0, ifc.mem_addr, ifc.mem_size), ifc.mem_size, ifc.mem_sign);
        end
    end

    // ---------------- requester agents ----------------
    for (genvar g = 0; g < 2; g++) begin : g_agent
        req_t        q [$];
        logic        a_valid = 1'b0;
        logic        a_store = 1'b0;
        logic        a_sign  = 1'b0;
        logic [31:0] a_addr  = 32'd0;
        logic [31:0] a_wdata = 32'd0;
        logic [2:0]  a_size  = 3'd0;
        bit          busy    = 1'b0;
        bit          stuck   = 1'b0;

        assign ifc.req_valid[g]         = a_valid;
        assign ifc.req_store[g]         = a_store;
        assign ifc.req_sign[g]          = a_sign;
        assign ifc.req_addr[32*g +: 32]  = a_addr;
        assign ifc.req_wdata[32*g +: 32] = a_wdata;
        assign ifc.req_size[3*g +: 3]    = a_size;

        initial begin
            req_t t;
            bit   acc;
            int   wcnt;
            acc  = 1'b0;
            wcnt = 0;
            forever begin
                @(posedge clk); #2;
                if (acc) begin
                    a_valid = 1'b0;
                    acc     = 1'b0;
                    busy    = 1'b0;
                end
                if (!a_valid && !rst && q.size() != 0) begin
                    t    = q.pop_front();
                    busy = 1'b1;
                    repeat (t.gap) begin @(posedge clk); #2; end
                    a_store = t.st;
                    a_addr  = t.addr;
                    a_wdata = t.data;
                    a_size  = t.size;
                    a_sign  = t.sign;
                    a_valid = 1'b1;
                    wcnt    = 0;
                end
                @(negedge clk);
                if (a_valid) begin
                    if (ifc.req_ready[g] && !rst) begin
                        acc = 1'b1;
                    end else begin
                        wcnt++;
                        if (wcnt > 200) begin
                            stuck   = 1'b1;
                            a_valid = 1'b0;
                            busy    = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- reference model: predicts grants, memory controls and responses ----------------
    initial begin
        int          ptr;
        bit          busy;
        int          w;
        cyc_t        e;
        rsp_t        r;
        logic [31:0] a;
        logic [2:0]  sz;
        longint      sum;
        bit          er;
        ptr  = 0;
        busy = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'd0;
        forever begin
            @(negedge clk);
            e = '0;
            if (rst) begin
                e.skip = 1'b1;
                ptr    = 0;
                busy   = 1'b0;
            end else if (busy) begin
                busy = 1'b0;
            end else begin
                w = -1;
                if (ifc.req_valid[ptr]) w = ptr;
                else if (ifc.req_valid[1-ptr]) w = 1 - ptr;
                if (w >= 0) begin
                    a   = ifc.req_addr[32*w +: 32];
                    sz  = ifc.req_size[3*w +: 3];
                    sum = a;
                    sum = sum + sz;
                    er  = !(sz == 3'd1 || sz == 3'd2 || sz == 3'd4) || (sum > MEM_BYTES);
                    e.ready[w] = 1'b1;
                    e.addr     = a;
                    e.wdata    = ifc.req_wdata[32*w +: 32];
                    e.size     = sz;
                    e.sign     = ifc.req_sign[w];
                    e.st       = ifc.req_store[w] && !er;
                    e.ld       = !ifc.req_store[w] && !er;
                    r.due      = cyc + (e.ld ? 2 : 1);
                    r.err      = er;
                    r.rdata    = e.ld ? extend(peek(1'b1, a, sz), sz, e.sign) : 32'd0;
                    if (e.st)
                        for (int k = 0; k < int'(sz); k++) ref_mem[bidx(a, k)] = e.wdata[8*k +: 8];
                    rsp_q[w].push_back(r);
                    ptr  = 1 - w;
                    busy = e.ld;
                end
            end
            cyc_q.push_back(e);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    initial begin
        cyc_t e;
        rsp_t r;
        bit   prev_rst;
        prev_rst = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (done) break;
            if (cyc_q.size() != 0) begin
                e = cyc_q.pop_front();
                if (!e.skip) begin
                    chk("req_ready", 128'(ifc.req_ready), 128'(e.ready));
                    chk("mem_ctrl",
                        128'({ifc.mem_store, ifc.mem_load, ifc.mem_addr, ifc.mem_wdata, ifc.mem_size, ifc.mem_sign}),
                        128'({e.st, e.ld, e.addr, e.wdata, e.size, e.sign}));
                end
            end
            if (prev_rst && !rst)
                chk("reset_rsp", 128'({ifc.rsp_valid, ifc.rsp_err, ifc.rsp_rdata}), 128'(0));
            for (int g = 0; g < 2; g++) begin
                if (ifc.rsp_valid[g]) begin
                    if (rsp_q[g].size() == 0) begin
                        chk($sformatf("rsp%0d_unexpected", g), 128'(ifc.rsp_valid[g]), 128'(0));
                    end else begin
                        r = rsp_q[g].pop_front();
                        chk($sformatf("rsp%0d_cycle", g), 128'(cyc), 128'(r.due));
                        chk($sformatf("rsp%0d_err", g), 128'(ifc.rsp_err), 128'(r.err));
                        chk($sformatf("rsp%0d_rdata", g), 128'(ifc.rsp_rdata), 128'(r.rdata));
                    end
                end else if (rsp_q[g].size() != 0 && rsp_q[g][0].due <= cyc) begin
                    r = rsp_q[g].pop_front();
                    chk($sformatf("rsp%0d_missing", g), 128'(ifc.rsp_valid[g]), 128'(1));
                end
            end
            // A reset cancels every response that would have landed after it.
            if (rst)
                for (int g = 0; g < 2; g++)
                    while (rsp_q[g].size() != 0 && rsp_q[g][$].due > cyc) void'(rsp_q[g].pop_back());
            prev_rst = rst;
        end
        chk("drain_timeout", 128'(drain_timeout), 128'(0));
        chk("agent0_stuck", 128'(g_agent[0].stuck), 128'(0));
        chk("agent1_stuck", 128'(g_agent[1].stuck), 128'(0));
        chk("rsp0_leftover", 128'(rsp_q[0].size()), 128'(0));
        chk("rsp1_leftover", 128'(rsp_q[1].size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- stimulus ----------------
    task automatic push(input int g, input bit st, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] sz, input bit sg, input int gap);
        req_t t;
        t.st = st; t.addr = a; t.data = d; t.size = sz; t.sign = sg; t.gap = gap;
        if (g == 0) g_agent[0].q.push_back(t);
        else        g_agent[1].q.push_back(t);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((g_agent[0].q.size() != 0 || g_agent[1].q.size() != 0 || g_agent[0].busy ||
                g_agent[1].busy || rsp_q[0].size() != 0 || rsp_q[1].size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) drain_timeout = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    logic [2:0] sz_tab [8] = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd1, 3'd2, 3'd3, 3'd0};

    initial begin
        int          n;
        logic [31:0] ra;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        push(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd4, 1'b0, 0);
        push(0, 1'b0, 32'h10, 32'd0, 3'd4, 1'b0, 0);
        push(0, 1'b0, 32'h10, 32'd0, 3'd1, 1'b1, 0);
        push(0, 1'b0, 32'h12, 32'd0, 3'd2, 1'b0, 0);
        push(0, 1'b0, 32'h12, 32'd0, 3'd2, 1'b1, 0);
        drain();

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b1, 32'h20 + 32'(4*i), $urandom, 3'd4, 1'b0, 0);
            push(1, 1'b1, 32'h40 + 32'(4*i), $urandom, 3'd4, 1'b0, 0);
        end
        drain();

        push(0, 1'b1, 32'h30, 32'h1, 3'd3, 1'b0, 0);
        push(0, 1'b0, 32'(MEM_BYTES - 2), 32'd0, 3'd4, 1'b0, 0);
        push(1, 1'b1, 32'hFFFFFFFD, 32'h55, 3'd4, 1'b0, 0);
        push(1, 1'b1, 32'(MEM_BYTES - 4), 32'hCAFEF00D, 3'd4, 1'b0, 0);
        push(1, 1'b0, 32'(MEM_BYTES - 4), 32'd0, 3'd4, 1'b0, 0);
        drain();

        @(posedge clk); #1;
        push(0, 1'b0, 32'h10, 32'd0, 3'd4, 1'b0, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ifc.req_valid[0] && ifc.req_ready[0]) && n < 100);
        if (n >= 100) drain_timeout = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        push(0, 1'b1, 32'h60, 32'h11111111, 3'd4, 1'b0, 0);
        push(1, 1'b1, 32'h64, 32'h22222222, 3'd4, 1'b0, 0);
        drain();

        @(posedge clk); #1;
        push(1, 1'b0, 32'h10, 32'd0, 3'd4, 1'b0, 0);
        push(0, 1'b1, 32'h50, 32'h12345678, 3'd4, 1'b0, 1);
        drain();

        for (int i = 0; i < 40; i++) begin
            for (int g = 0; g < 2; g++) begin
                case ($urandom_range(0, 9))
                    0:       ra = 32'(MEM_BYTES) - $urandom_range(0, 5);
                    1:       ra = 32'hFFFFFFF0 + $urandom_range(0, 15);
                    default: ra = $urandom_range(0, 127);
                endcase
                push(g, 1'($urandom_range(0, 1)), ra, $urandom, sz_tab[$urandom_range(0, 7)],
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
            end
        end
        drain();
        done = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the byte-addressed data memory.
  - Requester 0 is the core load/store path.
  - Requester 1 is the debug/loader port.
- Selects one request per slot with round-robin priority and drives the memory's store/load/size/sign/address/data controls.
- Captures load data on the memory's fixed one-cycle read latency and returns a tagged response to the winner.
- Rejects illegal sizes and out-of-range accesses without touching memory.

Parameters:
- MEM_BYTES, default `DATA_MEM_SIZE: data memory depth in bytes; used for the range check.
- NREQ, default 2: number of requesters. Fixed at 2; any other value is a configuration error.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  request present, bit i = requester i.
- req_store  in  2  1 = store, 0 = load, per requester.
- req_addr  in  64  byte address; requester i at [32i+31:32i].
- req_wdata  in  64  store data; same packing as req_addr.
- req_size  in  6  access bytes (1/2/4); requester i at [3i+2:3i].
- req_sign  in  2  1 = sign-extend load.
- req_ready  out  2  one-hot grant; request is accepted in a cycle where req_valid[i] & req_ready[i].
- rsp_valid  out  2  one-hot, one-cycle response pulse to the requester.
- rsp_err  out  1  response is an error; qualified by rsp_valid.
- rsp_rdata  out  32  load data (0 for stores and errors).
- mem_addr  out  32  to memory result input.
- mem_wdata  out  32  to memory data input.
- mem_store  out  1  to memory store_mem.
- mem_load  out  1  to memory load_mem.
- mem_size  out  3  to memory size.
- mem_sign  out  1  to memory sign.
- mem_rdata  in  32  from memory out_data.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE; round-robin pointer goes to requester 0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - Any pending load is discarded and produces no response.
- States: IDLE and LOAD_WAIT.
- IDLE, cycle T:
  - Arbitration is combinational over req_valid.
  - The pointer names the preferred requester. It wins if valid; otherwise the other valid requester wins.
  - req_ready is asserted for the winner only.
  - The winner's fields drive mem_* combinationally in T; the memory samples at the end of T.
  - After any grant, the pointer moves to the non-winner.
- Legal store:
  - mem_store=1 in T.
  - rsp_valid[w]=1 in T+1 with rsp_rdata=0.
  - State stays IDLE, so a new grant is possible in T+1 (one store per cycle).
- Legal load:
  - mem_load=1 in T; state goes to LOAD_WAIT.
  - In T+1: req_ready=0, mem_load=0, mem_store=0; mem_rdata is registered into rsp_rdata.
  - rsp_valid[w]=1 in T+2; state returns to IDLE at the end of T+1.
  - Load-to-response latency is 2 cycles; load throughput is one per 2 cycles.
- Error access:
  - Error if req_size is not in {1,2,4}, or if addr+size > MEM_BYTES.
  - The range sum is computed in 33 bits so address wrap is caught.
  - Still granted, but mem_store and mem_load stay 0.
  - rsp_valid[w]=1 with rsp_err=1 and rsp_rdata=0 in T+1; stays IDLE.
- Alignment: misaligned legal accesses are passed through unchanged; the memory is byte-addressed.
- Idle outputs: when nothing is granted, all mem_* outputs are 0.
- Load-data capture: the memory's out_data mirrors the address when load is low, so mem_rdata is sampled only in LOAD_WAIT.
- Requester obligations:
  - A requester holds its request until req_ready.
  - rsp_valid is not back-pressured; the requester must accept it.
  - The requester may present its next request in the same cycle as its response.
- Simultaneous valid requests: the pointer decides. After reset, requester 0 wins first.
- Reset during LOAD_WAIT: the in-flight memory read completes harmlessly, but no rsp_valid is produced.

Decomposition:
- Shared package dmem_pkg:
  - Size constants SZ_B=3'd1, SZ_H=3'd2, SZ_W=3'd4.
  - State enum {IDLE, LOAD_WAIT}.
  - Requester indices REQ_CORE=0, REQ_DBG=1.
- Sub-module rr_arb2: 2-way round-robin grant.
  - Inputs: req[1:0], advance.
  - Output: one-hot gnt.
  - Contains the pointer register and the synchronous reset.
- dmem_arbiter holds the FSM, range check, mux and response registers.

Test Plan:
- Core store word addr 0x10 data 0xDEADBEEF, then load word 0x10 -> store rsp at T+1; load rsp_valid[0] at T+2 with rdata 0xDEADBEEF, err=0.
- Loads after the above:
  - Signed byte 0x10 -> 0xFFFFFFEF.
  - Unsigned half 0x12 -> 0x0000DEAD.
  - Signed half 0x12 -> 0xFFFFDEAD.
- Both requesters issue stores every cycle from reset -> req_ready sequence 01,10,01,10 (core first); each rsp_valid lands one cycle after its grant.
- Error cases, each -> rsp_err=1 at T+1, mem_store=mem_load=0 throughout:
  - Size 3.
  - Addr MEM_BYTES-2 with size 4.
  - Addr 0xFFFFFFFD with size 4.
- Load granted, then rst=1 in the LOAD_WAIT cycle -> no rsp_valid ever; after reset, simultaneous requests grant requester 0.
- Debug load in flight while core holds a request -> core req_ready=0 in LOAD_WAIT; core granted in the cycle the debug rsp_valid fires.
